// File: rtl/branch_meta_pkg.sv
// Shared frontend types for carrying branch prediction metadata from fetch to
// backend resolution.
package branch_meta_pkg;

  localparam int BR_META_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic        guess;
    logic [1:0]  sat2;
  } br_meta_t;

endpackage

// File: rtl/branch_meta_queue.sv
// In-order queue of predicted-branch metadata; on each in-order commit it issues a
// registered update to the two-bit predictor and flags mispredictions.
module branch_meta_queue
  import branch_meta_pkg::*;
#(
  parameter int DEPTH = BR_META_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_pc,
  input  logic             push_guess,
  input  logic [1:0]       push_2bsat,
  input  logic             commit_valid,
  input  logic             commit_taken,
  input  logic             flush,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [31:0]      upd_pc,
  output logic [1:0]       upd_2bsat,
  output logic             mispredict,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  // Handshake: a push transfers on a cycle where push_valid && push_ready, and
  // push_ready depends only on registered occupancy. commit_valid has no ready;
  // the backend must never commit while empty, so such a commit is ignored.

  br_meta_t         mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;

  logic     full;
  logic     push_fire;
  logic     commit_fire;
  br_meta_t head_entry;

  always_comb begin
    full        = (cnt == (PTR_W+1)'(DEPTH));
    empty       = (cnt == '0);
    push_ready  = !full;
    count       = cnt;
    // A push coinciding with a flush belongs to the wrong path.
    push_fire   = push_valid && push_ready && !flush;
    commit_fire = commit_valid && !empty;
    head_entry  = mem[head];
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[tail] <= '{pc: push_pc, guess: push_guess, sat2: push_2bsat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      upd_valid  <= 1'b0;
      upd_taken  <= 1'b0;
      upd_pc     <= '0;
      upd_2bsat  <= '0;
      mispredict <= 1'b0;
    end else begin
      upd_valid  <= commit_fire;
      mispredict <= commit_fire && (commit_taken != head_entry.guess);
      if (commit_fire) begin
        upd_taken <= commit_taken;
        upd_pc    <= head_entry.pc;
        upd_2bsat <= head_entry.sat2;
      end
      // A same-cycle commit still produces its update above before the clear.
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push_fire)   tail <= tail + PTR_W'(1);
        if (commit_fire) head <= head + PTR_W'(1);
        case ({push_fire, commit_fire})
          2'b10:   cnt <= cnt + (PTR_W+1)'(1);
          2'b01:   cnt <= cnt - (PTR_W+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_meta_queue.sv
// Directed bench for branch_meta_queue: queue-based reference model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_branch_meta_queue;
  import branch_meta_pkg::*;

  localparam int DEPTH = BR_META_DEPTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int MW    = 35;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic             push_ready;
  logic [31:0]      push_pc;
  logic             push_guess;
  logic [1:0]       push_2bsat;
  logic             commit_valid;
  logic             commit_taken;
  logic             flush;
  logic             upd_valid;
  logic             upd_taken;
  logic [31:0]      upd_pc;
  logic [1:0]       upd_2bsat;
  logic             mispredict;
  logic [PTR_W:0]   count;
  logic             empty;

  int checks   = 0;
  int failures = 0;
  int illegal_cnt = 0;
  bit live = 1'b0;

  // Reference model: exp_q holds {pc, guess, sat2} of outstanding branches.
  logic [MW-1:0] exp_q[$];
  logic          m_valid, m_taken, m_mis;
  logic [31:0]   m_pc;
  logic [1:0]    m_sat;

  branch_meta_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_guess(push_guess), .push_2bsat(push_2bsat),
    .commit_valid(commit_valid), .commit_taken(commit_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
    .upd_2bsat(upd_2bsat), .mispredict(mispredict), .count(count), .empty(empty)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge from the inputs held across it.
  always @(posedge clk) begin
    logic [MW-1:0] e;
    bit acc_push;
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0; m_taken = 1'b0; m_mis = 1'b0; m_pc = '0; m_sat = '0;
      live = 1'b1;
    end else begin
      acc_push = push_valid && (exp_q.size() < DEPTH) && !flush;
      if (commit_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_valid = 1'b1;
        m_taken = commit_taken;
        m_pc    = e[34:3];
        m_sat   = e[1:0];
        m_mis   = (commit_taken != e[2]);
      end else begin
        m_valid = 1'b0;
        m_mis   = 1'b0;
        if (commit_valid) illegal_cnt++;
      end
      if (flush) exp_q.delete();
      else if (acc_push) exp_q.push_back({push_pc, push_guess, push_2bsat});
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("empty", 64'(empty), 64'(exp_q.size() == 0));
      chk("push_ready", 64'(push_ready), 64'(exp_q.size() < DEPTH));
      chk("upd_valid", 64'(upd_valid), 64'(m_valid));
      chk("mispredict", 64'(mispredict), 64'(m_mis));
      chk("upd_taken", 64'(upd_taken), 64'(m_taken));
      chk("upd_pc", 64'(upd_pc), 64'(m_pc));
      chk("upd_2bsat", 64'(upd_2bsat), 64'(m_sat));
    end
  end

  // Driver tasks: apply inputs for one edge, return #1 after it with inputs idle.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic g,
                       input logic [1:0] s, input logic cv, input logic ct,
                       input logic fl);
    push_valid = pv; push_pc = pc; push_guess = g; push_2bsat = s;
    commit_valid = cv; commit_taken = ct; flush = fl;
    @(posedge clk); #1;
    push_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic g, input logic [1:0] s);
    cycle(1'b1, pc, g, s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_commit(input logic t);
    cycle(1'b0, 32'h0, 1'b0, 2'b00, 1'b1, t, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_ready"}, 64'(push_ready), 64'd1);
    chk({tag, "_upd_valid"}, 64'(upd_valid), 64'd0);
    chk({tag, "_upd_taken"}, 64'(upd_taken), 64'd0);
    chk({tag, "_upd_pc"}, 64'(upd_pc), 64'd0);
    chk({tag, "_upd_2bsat"}, 64'(upd_2bsat), 64'd0);
    chk({tag, "_mispredict"}, 64'(mispredict), 64'd0);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    push_valid = 1'b0; push_pc = '0; push_guess = 1'b0; push_2bsat = '0;
    commit_valid = 1'b0; commit_taken = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");
    repeat (10) begin
      idle();
      chk("idle_empty", 64'(empty), 64'd1);
      chk("idle_upd_valid", 64'(upd_valid), 64'd0);
    end

    // Two pushes, two taken commits: the second one mispredicts.
    do_push(32'h100, 1'b1, 2'b10);
    do_push(32'h104, 1'b0, 2'b01);
    do_commit(1'b1);
    chk("c1_upd_valid", 64'(upd_valid), 64'd1);
    chk("c1_upd_pc", 64'(upd_pc), 64'h100);
    chk("c1_upd_2bsat", 64'(upd_2bsat), 64'h2);
    chk("c1_upd_taken", 64'(upd_taken), 64'd1);
    chk("c1_mispredict", 64'(mispredict), 64'd0);
    do_commit(1'b1);
    chk("c2_upd_pc", 64'(upd_pc), 64'h104);
    chk("c2_upd_2bsat", 64'(upd_2bsat), 64'h1);
    chk("c2_mispredict", 64'(mispredict), 64'd1);
    idle();
    chk("c2_pulse_once", 64'(upd_valid), 64'd0);

    // Fill to DEPTH; the extra push is dropped; drain in push order across the wrap.
    for (int i = 0; i < DEPTH; i++) do_push(32'h1000 + 32'(4 * i), 1'(i), 2'(i));
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(push_ready), 64'd0);
    do_push(32'hDEAD0, 1'b0, 2'b11);
    chk("overflow_count", 64'(count), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      do_commit(1'($urandom_range(0, 1)));
      chk("drain_pc", 64'(upd_pc), 64'h1000 + 64'(4 * i));
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_empty", 64'(empty), 64'd1);

    // Steady state at occupancy 5 with a push and a commit every cycle.
    for (int i = 0; i < 5; i++) do_push(32'h2000 + 32'(4 * i), 1'b1, 2'b11);
    for (int j = 0; j < 40; j++) begin
      pc = 32'h2000 + 32'(4 * (5 + j));
      cycle(1'b1, pc, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("steady_count", 64'(count), 64'd5);
      chk("steady_pc", 64'(upd_pc), 64'h2000 + 64'(4 * j));
    end
    repeat (5) do_commit(1'b0);
    chk("steady_drained", 64'(count), 64'd0);

    // Flush together with a commit and a push.
    do_push(32'h3000, 1'b1, 2'b11);
    do_push(32'h3004, 1'b0, 2'b00);
    do_push(32'h3008, 1'b1, 2'b10);
    cycle(1'b1, 32'h3FFC, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    chk("flush_upd_valid", 64'(upd_valid), 64'd1);
    chk("flush_upd_pc", 64'(upd_pc), 64'h3000);
    chk("flush_mispredict", 64'(mispredict), 64'd1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    do_push(32'h4000, 1'b0, 2'b01);
    do_commit(1'b0);
    chk("post_flush_pc", 64'(upd_pc), 64'h4000);

    // Commit while empty is ignored and flagged.
    do_commit(1'b1);
    chk("illegal_upd_valid", 64'(upd_valid), 64'd0);
    chk("illegal_count", 64'(count), 64'd0);
    chk("illegal_flagged", 64'(illegal_cnt), 64'd1);

    // Reset mid-stream with four entries queued.
    for (int i = 0; i < 4; i++) do_push(32'h5000 + 32'(4 * i), 1'b1, 2'b11);
    do_commit(1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
